// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants and types for the ID-stage hazard/forwarding unit.
// Forward-select encodings and the stall FSM state type.
package hfu_pkg;

   localparam logic [2:0] FWD_REGBANK = 3'b000;
   localparam logic [2:0] FWD_DMEM    = 3'b001;
   localparam logic [2:0] FWD_EXMEM   = 3'b010;
   localparam logic [2:0] FWD_ALU     = 3'b011;
   localparam logic [2:0] FWD_WB      = 3'b100;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      LU_STALL = 2'b01,
      MEM_WAIT = 2'b10
   } stall_state_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode/pipeline-register side bus of the hazard/forwarding unit.
// The pipeline (master) drives stage info; the unit (slave) returns selects and stall control.
interface hazard_forward_unit_if #(
   parameter int REG_AW = 5,
   parameter int NSRC   = 2,
   parameter int CNT_W  = 16
);
   import hfu_pkg::*;

   logic                   id_valid;
   logic [NSRC*REG_AW-1:0] id_src_addr;
   logic [NSRC-1:0]        id_src_used;
   logic                   id_is_branch;
   logic                   ex_valid;
   logic                   ex_regwrite;
   logic                   ex_memtoreg;
   logic [REG_AW-1:0]      ex_destadd;
   logic                   mem_valid;
   logic                   mem_regwrite;
   logic                   mem_memtoreg;
   logic [REG_AW-1:0]      mem_destadd;
   logic                   mem_rdata_valid;
   logic                   wb_regwrite;
   logic [REG_AW-1:0]      wb_destadd;
   logic [NSRC*3-1:0]      fwd_sel;
   logic                   stall_id;
   logic                   flush_ex;
   stall_state_t           stall_state;
   logic [CNT_W-1:0]       stall_cycles;
   logic                   mem_timeout;

   modport master (
      output id_valid, id_src_addr, id_src_used, id_is_branch,
      output ex_valid, ex_regwrite, ex_memtoreg, ex_destadd,
      output mem_valid, mem_regwrite, mem_memtoreg, mem_destadd, mem_rdata_valid,
      output wb_regwrite, wb_destadd,
      input  fwd_sel, stall_id, flush_ex, stall_state, stall_cycles, mem_timeout
   );

   modport slave (
      input  id_valid, id_src_addr, id_src_used, id_is_branch,
      input  ex_valid, ex_regwrite, ex_memtoreg, ex_destadd,
      input  mem_valid, mem_regwrite, mem_memtoreg, mem_destadd, mem_rdata_valid,
      input  wb_regwrite, wb_destadd,
      output fwd_sel, stall_id, flush_ex, stall_state, stall_cycles, mem_timeout
   );

endinterface

// File: rtl/hazard_forward_unit_fwd_src_resolve.sv
// Per-operand forward select (youngest producer first) and hazard flags.
module fwd_src_resolve
   import hfu_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int BR_ALU_STALL = 0
) (
   input  logic              id_valid,
   input  logic              used,
   input  logic [REG_AW-1:0] src,
   input  logic              id_is_branch,
   input  logic              ex_valid,
   input  logic              ex_regwrite,
   input  logic              ex_memtoreg,
   input  logic [REG_AW-1:0] ex_destadd,
   input  logic              mem_valid,
   input  logic              mem_regwrite,
   input  logic              mem_memtoreg,
   input  logic [REG_AW-1:0] mem_destadd,
   input  logic              mem_rdata_valid,
   input  logic              wb_regwrite,
   input  logic [REG_AW-1:0] wb_destadd,
   output logic              h_lu,
   output logic              h_mw,
   output logic              h_br,
   output logic [2:0]        sel
);

   logic active;
   logic ex_match;
   logic mem_match;
   logic wb_match;

   // Register 0 is hardwired, so it never matches a producer.
   assign active    = id_valid & used & (src != '0);
   assign ex_match  = active & ex_valid & ex_regwrite & (ex_destadd == src);
   assign mem_match = active & mem_valid & mem_regwrite & (mem_destadd == src);
   assign wb_match  = active & wb_regwrite & (wb_destadd == src);

   assign h_lu = ex_match & ex_memtoreg;
   assign h_mw = mem_match & mem_memtoreg & ~mem_rdata_valid;
   assign h_br = (BR_ALU_STALL != 0) & id_is_branch & ex_match & ~ex_memtoreg;

   always_comb begin
      sel = FWD_REGBANK;
      if (ex_match & ~ex_memtoreg & ~h_br)
         sel = FWD_ALU;
      else if (h_lu)
         sel = FWD_REGBANK;
      else if (mem_match & mem_memtoreg & mem_rdata_valid)
         sel = FWD_DMEM;
      else if (mem_match & ~mem_memtoreg)
         sel = FWD_EXMEM;
      else if (wb_match)
         sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard and forwarding controller: per-operand resolvers, stall FSM,
// saturating stall-cycle counter and sticky data-memory timeout flag.
module hazard_forward_unit
   import hfu_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int NSRC         = 2,
   parameter int BR_ALU_STALL = 0,
   parameter int MAX_WAIT     = 15,
   parameter int CNT_W        = 16
) (
   input logic                  clk,
   input logic                  rst,
   hazard_forward_unit_if.slave bus
);

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [NSRC-1:0]   h_lu;
   logic [NSRC-1:0]   h_mw;
   logic [NSRC-1:0]   h_br;
   logic [NSRC*3-1:0] sel_raw;

   logic any_lu;
   logic any_mw;
   logic any_br;
   logic stall;

   stall_state_t      state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
   logic              mem_timeout_q, mem_timeout_d;

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      fwd_src_resolve #(
         .REG_AW       (REG_AW),
         .BR_ALU_STALL (BR_ALU_STALL)
      ) u_resolve (
         .id_valid        (bus.id_valid),
         .used            (bus.id_src_used[i]),
         .src             (bus.id_src_addr[i*REG_AW +: REG_AW]),
         .id_is_branch    (bus.id_is_branch),
         .ex_valid        (bus.ex_valid),
         .ex_regwrite     (bus.ex_regwrite),
         .ex_memtoreg     (bus.ex_memtoreg),
         .ex_destadd      (bus.ex_destadd),
         .mem_valid       (bus.mem_valid),
         .mem_regwrite    (bus.mem_regwrite),
         .mem_memtoreg    (bus.mem_memtoreg),
         .mem_destadd     (bus.mem_destadd),
         .mem_rdata_valid (bus.mem_rdata_valid),
         .wb_regwrite     (bus.wb_regwrite),
         .wb_destadd      (bus.wb_destadd),
         .h_lu            (h_lu[i]),
         .h_mw            (h_mw[i]),
         .h_br            (h_br[i]),
         .sel             (sel_raw[i*3 +: 3])
      );
   end

   // Reset masks the combinational outputs so an in-flight stall leaves no trace.
   assign any_lu = |h_lu;
   assign any_mw = |h_mw;
   assign any_br = |h_br;
   assign stall  = ~rst & (any_lu | any_mw | any_br);

   assign bus.stall_id     = stall;
   assign bus.flush_ex     = stall;
   assign bus.fwd_sel      = rst ? '0 : sel_raw;
   assign bus.stall_state  = state_q;
   assign bus.stall_cycles = stall_cycles_q;
   assign bus.mem_timeout  = mem_timeout_q;

   always_comb begin
      state_d        = IDLE;
      wait_cnt_d     = wait_cnt_q;
      stall_cycles_d = stall_cycles_q;
      mem_timeout_d  = mem_timeout_q;

      // Memory wait outranks load-use when both are pending.
      if (any_mw)
         state_d = MEM_WAIT;
      else if (any_lu | any_br)
         state_d = LU_STALL;

      if ((state_q != MEM_WAIT) && (state_d == MEM_WAIT))
         wait_cnt_d = '0;
      else if ((state_q == MEM_WAIT) && (wait_cnt_q != WAIT_W'(MAX_WAIT)))
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);

      if (wait_cnt_d == WAIT_W'(MAX_WAIT))
         mem_timeout_d = 1'b1;

      if (stall && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         wait_cnt_q     <= '0;
         stall_cycles_q <= '0;
         mem_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         stall_cycles_q <= stall_cycles_d;
         mem_timeout_q  <= mem_timeout_d;
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit (NSRC=2, BR_ALU_STALL=1, MAX_WAIT=15).
module tb_hazard_forward_unit;
   import hfu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_forward_unit_if #(.REG_AW(5), .NSRC(2), .CNT_W(16)) bus ();

   hazard_forward_unit #(
      .REG_AW(5), .NSRC(2), .BR_ALU_STALL(1), .MAX_WAIT(15), .CNT_W(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic clear_inputs();
      bus.id_valid = 0; bus.id_src_addr = '0; bus.id_src_used = '0; bus.id_is_branch = 0;
      bus.ex_valid = 0; bus.ex_regwrite = 0; bus.ex_memtoreg = 0; bus.ex_destadd = '0;
      bus.mem_valid = 0; bus.mem_regwrite = 0; bus.mem_memtoreg = 0; bus.mem_destadd = '0;
      bus.mem_rdata_valid = 0; bus.wb_regwrite = 0; bus.wb_destadd = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic set_ex(input logic v, input logic ld, input logic [4:0] d);
      bus.ex_valid = v; bus.ex_regwrite = v; bus.ex_memtoreg = ld; bus.ex_destadd = d;
   endtask

   task automatic set_mem(input logic v, input logic ld, input logic [4:0] d, input logic rdv);
      bus.mem_valid = v; bus.mem_regwrite = v; bus.mem_memtoreg = ld; bus.mem_destadd = d;
      bus.mem_rdata_valid = rdv;
   endtask

   task automatic set_id(input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] used);
      bus.id_valid = 1; bus.id_src_addr = {s1, s0}; bus.id_src_used = used;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      set_id(5'd0, 5'd3, 2'b01);
      set_ex(1, 1, 5'd3);
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", bus.stall_id); end
      checks++; if (bus.flush_ex !== 1'b0) begin errors++; $display("FAIL rst_flush got %0b want 0", bus.flush_ex); end
      set_ex(1, 0, 5'd3);
      #1;
      checks++; if (bus.fwd_sel !== 6'b0) begin errors++; $display("FAIL rst_fwd got %b want 000000", bus.fwd_sel); end
      tick();
      rst = 0;
      clear_inputs();
      #1;
      checks++; if (bus.stall_state !== 2'b00) begin errors++; $display("FAIL rst_state got %b want 00", bus.stall_state); end
      checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", bus.stall_cycles); end
      checks++; if (bus.mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b want 0", bus.mem_timeout); end
   endtask

   task automatic test_alu_forward();
      do_reset();
      set_id(5'd0, 5'd3, 2'b01);
      set_ex(1, 0, 5'd3);
      #1;
      checks++; if (bus.fwd_sel[2:0] !== 3'b011) begin errors++; $display("FAIL alu_fwd got %b want 011", bus.fwd_sel[2:0]); end
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b want 0", bus.stall_id); end
      tick();
      checks++; if (bus.stall_state !== 2'b00) begin errors++; $display("FAIL alu_state got %b want 00", bus.stall_state); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(5'd0, 5'd5, 2'b01);
      set_ex(1, 1, 5'd5);
      #1;
      checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", bus.stall_id); end
      checks++; if (bus.flush_ex !== 1'b1) begin errors++; $display("FAIL lu_flush got %0b want 1", bus.flush_ex); end
      checks++; if (bus.fwd_sel[2:0] !== 3'b000) begin errors++; $display("FAIL lu_fwd got %b want 000", bus.fwd_sel[2:0]); end
      tick();
      checks++; if (bus.stall_state !== 2'b01) begin errors++; $display("FAIL lu_state got %b want 01", bus.stall_state); end
      set_ex(0, 0, 5'd0);
      set_mem(1, 1, 5'd5, 1);
      #1;
      checks++; if (bus.fwd_sel[2:0] !== 3'b001) begin errors++; $display("FAIL lu_dmem got %b want 001", bus.fwd_sel[2:0]); end
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL lu_release got %0b want 0", bus.stall_id); end
      checks++; if (bus.stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", bus.stall_cycles); end
      tick();
      checks++; if (bus.stall_state !== 2'b00) begin errors++; $display("FAIL lu_idle got %b want 00", bus.stall_state); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      set_id(5'd7, 5'd0, 2'b10);
      set_mem(1, 1, 5'd7, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL mw_stall%0d got %0b want 1", k, bus.stall_id); end
         tick();
         checks++; if (bus.stall_state !== 2'b10) begin errors++; $display("FAIL mw_state%0d got %b want 10", k, bus.stall_state); end
      end
      bus.mem_rdata_valid = 1;
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL mw_release got %0b want 0", bus.stall_id); end
      checks++; if (bus.fwd_sel[5:3] !== 3'b001) begin errors++; $display("FAIL mw_dmem got %b want 001", bus.fwd_sel[5:3]); end
      checks++; if (bus.stall_cycles !== 16'd3) begin errors++; $display("FAIL mw_cnt got %0d want 3", bus.stall_cycles); end
      tick();
      checks++; if (bus.stall_state !== 2'b00) begin errors++; $display("FAIL mw_idle got %b want 00", bus.stall_state); end
   endtask

   task automatic test_priority();
      do_reset();
      set_id(5'd0, 5'd4, 2'b01);
      set_ex(1, 0, 5'd4);
      set_mem(1, 0, 5'd4, 0);
      bus.wb_regwrite = 1; bus.wb_destadd = 5'd4;
      #1;
      checks++; if (bus.fwd_sel[2:0] !== 3'b011) begin errors++; $display("FAIL pri_ex got %b want 011", bus.fwd_sel[2:0]); end
      set_ex(0, 0, 5'd0);
      #1;
      checks++; if (bus.fwd_sel[2:0] !== 3'b010) begin errors++; $display("FAIL pri_mem got %b want 010", bus.fwd_sel[2:0]); end
      set_mem(0, 0, 5'd0, 0);
      #1;
      checks++; if (bus.fwd_sel[2:0] !== 3'b100) begin errors++; $display("FAIL pri_wb got %b want 100", bus.fwd_sel[2:0]); end
      bus.id_src_used = 2'b00;
      #1;
      checks++; if (bus.fwd_sel !== 6'b0) begin errors++; $display("FAIL pri_unused got %b want 000000", bus.fwd_sel); end
      set_id(5'd0, 5'd0, 2'b11);
      set_ex(1, 1, 5'd0);
      set_mem(1, 1, 5'd0, 0);
      bus.wb_destadd = 5'd0;
      #1;
      checks++; if (bus.fwd_sel !== 6'b0) begin errors++; $display("FAIL pri_r0 got %b want 000000", bus.fwd_sel); end
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL pri_r0_stall got %0b want 0", bus.stall_id); end
      set_id(5'd9, 5'd1, 2'b11);
      set_ex(1, 0, 5'd9);
      set_mem(1, 0, 5'd1, 0);
      bus.wb_regwrite = 0;
      #1;
      checks++; if (bus.fwd_sel !== 6'b011_010) begin errors++; $display("FAIL pri_two_ops got %b want 011010", bus.fwd_sel); end
   endtask

   task automatic test_branch();
      do_reset();
      set_id(5'd0, 5'd2, 2'b01);
      set_ex(1, 0, 5'd2);
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL br_nonbranch_stall got %0b want 0", bus.stall_id); end
      bus.id_is_branch = 1;
      #1;
      checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL br_stall got %0b want 1", bus.stall_id); end
      checks++; if (bus.fwd_sel[2:0] !== 3'b000) begin errors++; $display("FAIL br_fwd got %b want 000", bus.fwd_sel[2:0]); end
      tick();
      checks++; if (bus.stall_state !== 2'b01) begin errors++; $display("FAIL br_state got %b want 01", bus.stall_state); end
      set_ex(0, 0, 5'd0);
      set_mem(1, 0, 5'd2, 0);
      #1;
      checks++; if (bus.fwd_sel[2:0] !== 3'b010) begin errors++; $display("FAIL br_mem got %b want 010", bus.fwd_sel[2:0]); end
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL br_release got %0b want 0", bus.stall_id); end
      tick();
      checks++; if (bus.stall_state !== 2'b00) begin errors++; $display("FAIL br_idle got %b want 00", bus.stall_state); end
   endtask

   task automatic test_lu_mw_priority();
      do_reset();
      set_id(5'd7, 5'd5, 2'b11);
      set_ex(1, 1, 5'd5);
      set_mem(1, 1, 5'd7, 0);
      #1;
      checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL both_stall got %0b want 1", bus.stall_id); end
      tick();
      checks++; if (bus.stall_state !== 2'b10) begin errors++; $display("FAIL both_state got %b want 10", bus.stall_state); end
      set_mem(0, 0, 5'd0, 0);
      tick();
      checks++; if (bus.stall_state !== 2'b01) begin errors++; $display("FAIL mw_to_lu got %b want 01", bus.stall_state); end
   endtask

   task automatic test_timeout();
      do_reset();
      set_id(5'd0, 5'd7, 2'b01);
      set_mem(1, 1, 5'd7, 0);
      tick();
      repeat (14) tick();
      checks++; if (bus.mem_timeout !== 1'b0) begin errors++; $display("FAIL to_early got %0b want 0", bus.mem_timeout); end
      tick();
      checks++; if (bus.mem_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %0b want 1", bus.mem_timeout); end
      checks++; if (bus.stall_cycles !== 16'd16) begin errors++; $display("FAIL to_cnt got %0d want 16", bus.stall_cycles); end
      checks++; if (bus.stall_state !== 2'b10) begin errors++; $display("FAIL to_state got %b want 10", bus.stall_state); end
      bus.mem_rdata_valid = 1;
      tick();
      checks++; if (bus.mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b want 1", bus.mem_timeout); end
      checks++; if (bus.stall_state !== 2'b00) begin errors++; $display("FAIL to_idle got %b want 00", bus.stall_state); end
      bus.mem_rdata_valid = 0;
      tick();
      rst = 1;
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL to_rst_stall got %0b want 0", bus.stall_id); end
      checks++; if (bus.fwd_sel !== 6'b0) begin errors++; $display("FAIL to_rst_fwd got %b want 000000", bus.fwd_sel); end
      tick();
      rst = 0;
      clear_inputs();
      #1;
      checks++; if (bus.stall_state !== 2'b00) begin errors++; $display("FAIL to_rst_state got %b want 00", bus.stall_state); end
      checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL to_rst_cnt got %0d want 0", bus.stall_cycles); end
      checks++; if (bus.mem_timeout !== 1'b0) begin errors++; $display("FAIL to_rst_timeout got %0b want 0", bus.mem_timeout); end
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL to_residual got %0b want 0", bus.stall_id); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_alu_forward();
      test_load_use();
      test_mem_wait();
      test_priority();
      test_branch();
      test_lu_mw_priority();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised ID-stage hazard and forwarding controller for the pipelined KGP-RISC core, successor to the fixed two-operand forwarding selector. It serves NSRC source operands and computes per-operand forward selects with youngest-producer priority. It detects load-use and multi-cycle data-memory hazards and drives stall/bubble control through a stall FSM. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag. It sits between the decode stage and the ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
REG_AW, 5, register address width
NSRC, 2, number of source operands checked per instruction
BR_ALU_STALL, 0, 1 = branch in ID that depends on an EX-stage ALU result stalls one cycle instead of forwarding 011
MAX_WAIT, 15, maximum consecutive MEM_WAIT cycles before mem_timeout sets
CNT_W, 16, stall counter width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_src_addr  in  NSRC*REG_AW  source register addresses; operand i occupies bits [i*REG_AW +: REG_AW]
id_src_used  in  NSRC  operand i is actually read
id_is_branch  in  1  ID instruction is a branch resolved in ID
ex_valid, ex_regwrite, ex_memtoreg  in  1 each  ID/EX control
ex_destadd  in  REG_AW  ID/EX destination
mem_valid, mem_regwrite, mem_memtoreg  in  1 each  EX/MEM control
mem_destadd  in  REG_AW  EX/MEM destination
mem_rdata_valid  in  1  data memory read data available this cycle
wb_regwrite  in  1  MEM/WB write enable
wb_destadd  in  REG_AW  MEM/WB destination
fwd_sel  out  NSRC*3  per-operand select: 000 regbank, 001 dmem data, 010 ex_mem result, 011 ALU result, 100 wb writedata
stall_id  out  1  hold PC and IF/ID
flush_ex  out  1  insert bubble into ID/EX
stall_state  out  2  FSM state: 00 IDLE, 01 LU_STALL, 10 MEM_WAIT
stall_cycles  out  CNT_W  saturating count of stalled cycles
mem_timeout  out  1  sticky error flag

Behaviour:
- Operand i is active when id_valid & id_src_used[i] & (src_i != 0). Register 0 is never forwarded and never causes a hazard.
- Per active operand, hazard conditions:
  - H_LU: ex_valid & ex_regwrite & ex_memtoreg & ex_destadd == src.
  - H_MW: mem_valid & mem_regwrite & mem_memtoreg & mem_destadd == src & !mem_rdata_valid.
  - H_BR: BR_ALU_STALL & id_is_branch & ex_valid & ex_regwrite & !ex_memtoreg & ex_destadd == src.
- stall_id = flush_ex = OR of all hazards over all operands. These outputs are combinational and take effect in the same cycle.
- fwd_sel is combinational, evaluated first match wins:
  - EX non-load match and !H_BR -> 011
  - MEM load match with mem_rdata_valid -> 001
  - MEM non-load match -> 010
  - wb_regwrite & wb_destadd == src -> 100
  - else 000
- EX outranks MEM, and MEM outranks WB (youngest producer wins).
- On an EX load match, fwd_sel is 000; stall_id covers this case.
- FSM transitions (registered, evaluated on clk):
  - IDLE -> LU_STALL on H_LU or H_BR.
  - IDLE -> MEM_WAIT on H_MW.
  - LU_STALL -> MEM_WAIT if H_MW; -> IDLE if no hazard; stays in LU_STALL on a new H_LU.
  - MEM_WAIT -> IDLE when no hazard remains; stays in MEM_WAIT while H_MW persists.
- wait_cnt:
  - Clears on entering MEM_WAIT.
  - Increments each cycle spent in MEM_WAIT.
  - When wait_cnt reaches MAX_WAIT, mem_timeout sets and holds until rst. The FSM keeps waiting; there is no forced exit.
- stall_cycles increments on every cycle with stall_id = 1 and saturates at all-ones.
- Simultaneous H_LU and H_MW on different operands: state goes to MEM_WAIT (MEM_WAIT has priority).
- Reset: in the cycle rst is high, stall_id = 0, flush_ex = 0 and fwd_sel = 0. Next cycle: stall_state = IDLE, stall_cycles = 0, wait_cnt = 0, mem_timeout = 0. A reset during a stall aborts it with no residual stall.

Decomposition:
- Package hfu_pkg holds:
  - FWD_REGBANK/FWD_DMEM/FWD_EXMEM/FWD_ALU/FWD_WB 3-bit constants
  - stall_state_t enum (IDLE, LU_STALL, MEM_WAIT)
- Sub-module fwd_src_resolve: combinational per-operand priority and hazard flags (h_lu, h_mw, h_br, sel). Instantiated NSRC times via generate.
- The top level holds the FSM, counters and the reduction ORs.

Test Plan:
- EX add r3, ID reads r3 (op0) -> fwd_sel[2:0] = 011, stall_id = 0, state stays IDLE.
- EX lw r5, ID reads r5 -> stall_id = 1 for 1 cycle, state 01. Next cycle, with the load in MEM and mem_rdata_valid = 1 -> fwd_sel = 001, stall_id = 0.
- MEM lw r7 with mem_rdata_valid low for 3 cycles, ID reads r7 (op1) -> stall_id high exactly 3 cycles, state 10, stall_cycles = 3; on the 4th cycle fwd_sel[5:3] = 001.
- Same register r4 written in EX (non-load), MEM and WB -> 011. Remove EX -> 010. Remove MEM -> 100. Address r0 in all stages -> 000.
- BR_ALU_STALL = 1, branch in ID reading r2, EX writes r2 via ALU -> 1-cycle stall, then 010 from MEM.
- MEM_WAIT held for 15 cycles -> mem_timeout = 1 and stays high. Assert rst mid-stall -> outputs 0 that cycle; next cycle state 00, counters 0, mem_timeout 0.
